// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;
  localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam int          MAX_DEPTH    = 16;

  // Queue entry layout; the fetch queue packs its FIFO word in this order.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; DEPTH need not be a power of two.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clear) assert (!(push && count == CW'(DEPTH)));
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues fixed-latency imem requests and
// queues returned instructions ahead of Decode, with credit-based flow control.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(DEF_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [DATA_W-1:0]          redirect_pc,
  output logic                       imem_en,
  output logic [DATA_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       dec_valid,
  output logic [DATA_W-1:0]          dec_instr,
  output logic [DATA_W-1:0]          dec_pc_plus4,
  input  logic                       dec_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  logic [DATA_W-1:0]   pc_q, req_pc_q;
  logic                inflight_q;
  logic                pop, push, issue;
  logic [CW:0]         credit;
  logic [2*DATA_W-1:0] head;

  assign pop       = dec_valid & dec_ready;
  assign dec_valid = (count != '0) & ~redirect;

  // Occupancy the queue will have if a new request is issued now; keeps
  // count + inflight within DEPTH so every return has a slot.
  assign credit    = {1'b0, count} + CW1'(inflight_q) - CW1'(pop);
  assign issue     = ~rst & (redirect | (credit < CW1'(DEPTH)));
  assign imem_en   = issue;
  assign imem_addr = redirect ? {redirect_pc[DATA_W-1:2], 2'b00} : pc_q;

  // A redirect kills the returning instruction of the old path.
  assign push = inflight_q & ~redirect & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= imem_addr + DATA_W'(4);
        req_pc_q <= imem_addr;
      end
    end
  end

  sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clear (rst | redirect),
    .push  (push),
    .din   ({imem_rdata, req_pc_q + DATA_W'(4)}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign {dec_instr, dec_pc_plus4} = head;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table on DEPTH=4 plus a stream
// scoreboard running on DEPTH=4/3/2 instances under random stimulus.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam logic [31:0] K    = 32'h1234_5678;
  localparam int          NDUT = 3;

  logic        clk = 1'b0, rst = 1'b1, redirect = 1'b0, dec_ready = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        en_a [NDUT], vld_a [NDUT];
  logic [31:0] addr_a [NDUT], instr_a [NDUT], pc4_a [NDUT];
  logic [4:0]  cnt_a [NDUT];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int D = 4 - g;
    logic [$clog2(D+1)-1:0] cnt;
    logic [31:0] rdata, addr, instr, pc4;
    logic        en, vld;

    // Instruction memory: 1-cycle latency, content derived from the address.
    always @(posedge clk) rdata <= addr ^ K;

    fetch_queue #(.DATA_W(32), .DEPTH(D), .RESET_PC(DEF_RESET_PC)) u_dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_en(en), .imem_addr(addr), .imem_rdata(rdata),
      .dec_valid(vld), .dec_instr(instr), .dec_pc_plus4(pc4),
      .dec_ready(dec_ready), .count(cnt));

    assign en_a[g] = en;     assign vld_a[g] = vld;
    assign addr_a[g] = addr; assign instr_a[g] = instr;
    assign pc4_a[g] = pc4;   assign cnt_a[g] = 5'(cnt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: delivered instructions form the sequential word stream that
  // starts at RESET_PC or the latest redirect target, with credit-limited issue.
  logic [31:0] exp_pc [NDUT], fpc [NDUT];
  bit          prev_en [NDUT];
  int          pops [NDUT];

  task automatic sb();
    bit p; int room; logic [31:0] tgt, ea;
    tgt = {redirect_pc[31:2], 2'b00};
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        chk($sformatf("d%0d en_in_rst", i), 32'(en_a[i]), 32'd0);
        exp_pc[i] = DEF_RESET_PC; fpc[i] = DEF_RESET_PC; prev_en[i] = 1'b0;
      end else begin
        p    = vld_a[i] & dec_ready;
        room = int'(cnt_a[i]) + int'(prev_en[i]) - int'(p);
        chk($sformatf("d%0d valid", i), 32'(vld_a[i]), 32'(cnt_a[i] != 0 && !redirect));
        chk($sformatf("d%0d credit", i), 32'(int'(cnt_a[i]) + int'(prev_en[i]) <= 4 - i), 32'd1);
        chk($sformatf("d%0d issue", i), 32'(en_a[i]), 32'(redirect || room < 4 - i));
        if (en_a[i]) begin
          ea = redirect ? tgt : fpc[i];
          chk($sformatf("d%0d addr", i), addr_a[i], ea);
          fpc[i] = ea + 32'd4;
        end
        if (redirect) exp_pc[i] = tgt;
        else if (p) begin
          chk($sformatf("d%0d pc4", i), pc4_a[i], exp_pc[i] + 32'd4);
          chk($sformatf("d%0d instr", i), instr_a[i], exp_pc[i] ^ K);
          exp_pc[i] += 32'd4;
          pops[i]++;
        end
        prev_en[i] = en_a[i];
      end
    end
  endtask

  task automatic sample();  @(negedge clk); sb(); endtask
  task automatic advance(); @(posedge clk); #1; endtask

  typedef struct {
    bit rst, redir; logic [31:0] rpc; bit rdy;
    bit en; logic [31:0] addr; bit ca; bit vld; logic [31:0] pc4; bit cp; int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit r, bit rd, logic [31:0] rpc, bit rdy, bit en,
                             logic [31:0] a, bit ca, bit vl, logic [31:0] p4, bit cp, int c);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rpc; t.rdy = rdy; t.en = en; t.addr = a;
    t.ca = ca; t.vld = vl; t.pc4 = p4; t.cp = cp; t.cnt = c;
    return t;
  endfunction

  initial begin
    int base, thr;
    for (int i = 0; i < NDUT; i++) begin
      pops[i] = 0; prev_en[i] = 0; exp_pc[i] = DEF_RESET_PC; fpc[i] = DEF_RESET_PC;
    end
    // rst rdr rpc rdy | en addr ca vld pc4 cp cnt
    tbl.push_back(v(1,0,0,0, 0,32'hBFC00000,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00000,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00004,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00008,1, 1,32'hBFC00004,1, 1));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC0000C,1, 1,32'hBFC00008,1, 1));
    tbl.push_back(v(0,0,0,0, 1,32'hBFC00010,1, 1,32'hBFC0000C,1, 1));
    tbl.push_back(v(0,0,0,0, 1,32'hBFC00014,1, 1,32'hBFC0000C,1, 2));
    tbl.push_back(v(0,0,0,0, 0,32'hBFC00018,1, 1,32'hBFC0000C,1, 3));
    tbl.push_back(v(0,0,0,0, 0,32'hBFC00018,1, 1,32'hBFC0000C,1, 4));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00018,1, 1,32'hBFC0000C,1, 4));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC0001C,1, 1,32'hBFC00010,1, 3));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00020,1, 1,32'hBFC00014,1, 3));
    tbl.push_back(v(0,1,32'h80000101,1, 1,32'h80000100,1, 0,0,0, 3));
    tbl.push_back(v(0,0,0,1, 1,32'h80000104,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'h80000108,1, 1,32'h80000104,1, 1));
    tbl.push_back(v(0,1,32'h00001000,1, 1,32'h00001000,1, 0,0,0, 1));
    tbl.push_back(v(0,1,32'h00002000,1, 1,32'h00002000,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'h00002004,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'h00002008,1, 1,32'h00002004,1, 1));
    tbl.push_back(v(0,0,0,0, 1,32'h0000200C,1, 1,32'h00002008,1, 1));
    tbl.push_back(v(0,0,0,0, 1,32'h00002010,1, 1,32'h00002008,1, 2));
    tbl.push_back(v(1,0,0,0, 0,0,0,          1,32'h00002008,1, 3));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00000,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00004,1, 0,0,0, 0));
    tbl.push_back(v(0,0,0,1, 1,32'hBFC00008,1, 1,32'hBFC00004,1, 1));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      rst = tbl[k].rst; redirect = tbl[k].redir; redirect_pc = tbl[k].rpc; dec_ready = tbl[k].rdy;
      sample();
      chk($sformatf("row%0d imem_en", k), 32'(en_a[0]), 32'(tbl[k].en));
      chk($sformatf("row%0d dec_valid", k), 32'(vld_a[0]), 32'(tbl[k].vld));
      chk($sformatf("row%0d count", k), 32'(cnt_a[0]), 32'(tbl[k].cnt));
      if (tbl[k].ca) chk($sformatf("row%0d imem_addr", k), addr_a[0], tbl[k].addr);
      if (tbl[k].cp) chk($sformatf("row%0d dec_pc_plus4", k), pc4_a[0], tbl[k].pc4);
      advance();
    end

    // Long Decode stall: queue saturates and fetch stops, then drains in order.
    rst = 1'b0; redirect = 1'b0; dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 9) begin
        chk("stall count", 32'(cnt_a[0]), 32'd4);
        chk("stall imem_en", 32'(en_a[0]), 32'd0);
      end
      advance();
    end
    base = pops[0];
    dec_ready = 1'b1;
    repeat (20) begin sample(); advance(); end
    chk("drain progress", 32'(pops[0] - base >= 15), 32'd1);

    // Random traffic on all depths.
    thr = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) thr = int'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 399) == 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      dec_ready   = (int'($urandom_range(0, 3)) >= thr);
      sample();
      advance();
    end
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("d%0d liveness", i), 32'(pops[i] > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the 5-stage MIPS core: owns the fetch PC, issues requests to a fixed-latency instruction memory, and buffers returned instructions in a DEPTH-entry queue ahead of Decode. Decode stalls are absorbed by the queue, so decode-stall back-pressure no longer reaches the memory enable directly. Branch/jump redirects flush the queue and kill the outstanding request. The queue sits between the instruction memory and the D-stage pipeline register.

## Interface
- DATA_W, 32: instruction and PC width.
- DEPTH, 4: queue entries; legal range 2–16.
- RESET_PC, 32'hBFC0_0000: first fetch address after reset.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- redirect  in  1  taken branch/jump resolved in Decode.
- redirect_pc  in  DATA_W  target; bits [1:0] forced to 0.
- imem_en  out  1  request valid this cycle.
- imem_addr  out  DATA_W  byte address of the request, word aligned.
- imem_rdata  in  DATA_W  instruction for the request issued the previous cycle; fixed 1-cycle latency, no back-pressure.
- dec_valid  out  1  queue head is valid.
- dec_instr  out  DATA_W  head instruction.
- dec_pc_plus4  out  DATA_W  head PC + 4.
- dec_ready  in  1  Decode accepts the head (not stalled).
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: pc_q (next sequential fetch address), inflight_q (request outstanding), queue (rd ptr, wr ptr, count).
- pop = dec_valid & dec_ready.
- issue = rst_n_cond & (redirect | (count + inflight_q − pop < DEPTH)).
- imem_addr = redirect ? redirect_pc : pc_q. imem_en = issue.
- On issue: pc_q <= imem_addr + 4 and inflight_q <= 1. Otherwise inflight_q <= 0.
- Return: when inflight_q = 1 and redirect = 0, push {imem_rdata, PC+4 of that request} into the queue. The PC of the outstanding request is held in a 1-entry register.
- Redirect (highest priority):
  - queue cleared (count <= 0);
  - the returning instruction is dropped;
  - pop is ignored;
  - dec_valid is forced to 0 in that cycle;
  - redirect_pc is issued in the same cycle.
- Credit rule: count + inflight_q never exceeds DEPTH, so no push is lost. Pushing when full is impossible by construction; an assertion checks it.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap uses explicit compare.
- dec_valid = (count != 0) & ~redirect.
- PC arithmetic is modulo 2^DATA_W; wrap past all-ones is not flagged.

## Timing
- Reset values, after the rst edge: pc_q = RESET_PC, inflight_q = 0, count = 0, pointers = 0, dec_valid = 0, imem_en = 0 while rst = 1.
- A return arriving in the cycle after rst drops is discarded (inflight_q = 0).
- First cycle after rst deasserts: imem_en = 1, imem_addr = RESET_PC.
- Fetch-to-decode latency with an empty queue is 2 cycles:
  - issue in cycle N;
  - push at end of N+1;
  - dec_valid in N+2.
- Redirect in cycle N: target issued in N; target instruction presented at Decode in N+2.
- Throughput: 1 instruction/cycle sustained with dec_ready = 1, for any DEPTH ≥ 2.
- rst mid-operation overrides redirect, issue and pop in the same cycle.

## Structure
- Package fetch_pkg holds:
  - RESET_PC default;
  - entry typedef {instr, pc_plus4};
  - MAX_DEPTH = 16.
- Sub-module sync_fifo: parametrised width/depth, synchronous clear, push/pop/count.
- fetch_queue itself holds only the PC, inflight and credit logic.
- The D-stage instruction and PC+4 registers in the datapath are replaced by dec_instr/dec_pc_plus4. Datapath Instr_en becomes dec_ready.

## Test plan
- Reset, then dec_ready = 1 and imem returns addr ^ 32'h1234_5678:
  - requests go to BFC00000, BFC00004, …;
  - dec_valid rises 2 cycles after the first issue;
  - one instruction per cycle, with dec_pc_plus4 = BFC00004, BFC00008, ….
- Hold dec_ready = 0 for 10 cycles with DEPTH = 4:
  - count saturates at 4 and imem_en drops after 4 requests;
  - release dec_ready: entries drain in order with no loss or duplicate, and imem_en resumes.
- Redirect to 8000_0100 while count = 3 and a request is in flight:
  - in the same cycle, dec_valid = 0 and imem_addr = 8000_0100;
  - next cycle count = 0;
  - two cycles later dec_pc_plus4 = 8000_0104;
  - stale data never appears.
- Redirect in two consecutive cycles (to A, then B): only B's instruction is presented.
- Assert rst with queue full and a request in flight:
  - next cycle count = 0 and dec_valid = 0;
  - after release, fetch restarts at BFC00000.
- DEPTH = 2 and DEPTH = 3 builds with random dec_ready: in-order, lossless delivery (scoreboard); count + inflight never exceeds DEPTH.
